seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the team's hex-to-seven-segment encoder. The block samples a multiplexed, active-low 7-segment display bus (segments plus digit anodes) driven from another board or a DUT and qualifies each digit's pattern over time. It decodes each qualified pattern back to a hex nibble, decimal-point flag and blank/invalid status. It sits on the lab board's GPIO inputs as a display monitor and self-check block.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥1)
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (≥2)
- IDX_W, max(1, clog2(NUM_DIGITS)), width of digit index

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_n  in  8  segment bus, active-low; bit7 = dp, bits 6:0 = g..a; asynchronous to clk
- an_n  in  NUM_DIGITS  digit anodes, active-low; asynchronous to clk
- hex_out  out  4*NUM_DIGITS  decoded nibble per digit, digit i at [4i+3:4i]
- dp_out  out  NUM_DIGITS  decimal point lit (active-high)
- blank  out  NUM_DIGITS  digit captured with all segments off
- bad  out  NUM_DIGITS  digit captured with a pattern not in the code table
- upd_valid  out  1  one-cycle pulse when a digit is captured
- upd_idx  out  IDX_W  index of the captured digit, valid with upd_valid
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame_done
- conflict  out  1  one-cycle pulse per synchronized sample with more than one anode asserted

## Operation
- Two-flop synchronizer on seg_n and an_n. All logic below uses synchronized values.
- Code table on seg_n[6:0], nibble 0–F: 40,79,24,30,19,12,02,78,00,10,23,03,27,21,06,0E (hex). The all-off pattern 7F is blank. Every other pattern is bad.
- Decimal point: dp_out = ~seg_n[7].
- Qualifier states:
  - IDLE: zero anodes asserted, or more than one anode asserted. Counter = 0. Leave for DWELL when a sample has exactly one anode asserted.
  - DWELL: the counter increments while the {seg_n, an_n} sample equals the previous sample and exactly one anode is asserted. Any difference sets counter = 1 (the new sample counts as the first). The count value reaching STABLE_CYCLES triggers a capture and moves to HELD.
  - HELD: no further capture while the sample is unchanged. Any change returns to DWELL with count 1, or to IDLE if the anode condition fails.
- Capture writes the active digit's hex_out, dp_out, blank and bad fields, and pulses upd_valid with upd_idx. On bad or blank, hex_out for that digit is written 0. blank and bad are mutually exclusive.
- Frame mask: a NUM_DIGITS-bit register gets its bit set on capture. When a capture completes the mask, frame_done pulses in the same cycle as upd_valid and the mask clears. Recapturing a digit already in the mask updates its data and leaves the mask unchanged.
- An anode index ≥ NUM_DIGITS cannot occur (width-matched).

## Timing
- Reset values: hex_out=0, dp_out=0, blank=all 1, bad=0, upd_valid=0, upd_idx=0, frame_done=0, conflict=0. Synchronizer flops, counter, state (IDLE) and mask are also cleared.
- Latency: a pattern stable at the pins from edge E yields registered outputs and an upd_valid pulse on edge E+1+STABLE_CYCLES. This is 2 synchronizer edges plus STABLE_CYCLES qualifier samples; the capture edge is the same edge as the last counted sample.
- A dwell shorter than STABLE_CYCLES samples never captures.
- conflict is registered and appears 1 cycle after the offending synchronized sample.
- upd_valid, frame_done and conflict are single-cycle pulses. Pulses are never stretched or queued.
- Reset asserted mid-dwell or mid-frame: immediate asynchronous clear, with no capture on the release edge. Counting restarts from the first post-reset sample.

## Structure
- Shared package seg7_pkg holds:
  - the 16 segment code constants (shared with the encoder)
  - the BLANK_CODE (7F) constant
  - the qualifier state enum (IDLE, DWELL, HELD)
- One sub-module, seg7_pattern_decode: combinational seg[6:0] → {nibble, blank, bad}, instantiated once on the synchronized bus.

## Test plan
- Reset, then an_n=1110 and seg_n=C0 held for 10 cycles → exactly one upd_valid with upd_idx=0; hex_out[3:0]=0, dp_out[0]=0, blank[0]=0, bad[0]=0; pulse occurs STABLE_CYCLES+1 edges after the stimulus edge.
- Scan digits 0..3 with seg_n=F9,A4,B0,0E (dp lit on digit 3), 8 cycles each → hex_out=16'hF321, dp_out=4'b1000, frame_done pulses once together with the digit-3 upd_valid.
- an_n=1101, seg_n=A4 held only STABLE_CYCLES-1 cycles, then changed → no upd_valid; outputs unchanged.
- an_n=1100 (two anodes) for 3 cycles → conflict pulses 3 times; no capture.
- an_n=1011, seg_n=FF then later 0xD5 → blank[2]=1 then bad[2]=1, hex_out[11:8]=0 in both cases.
- Mid-frame: capture digits 0 and 1, assert rst for 1 cycle → all outputs return to reset values; capturing digits 2 and 3 alone then produces no frame_done.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes (g..a), blank code
// and the receive-side qualifier state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h23;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h27;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Indexed by nibble value: SEG_CODE[n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_CODE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    localparam logic [6:0] BLANK_CODE = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } qual_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble,
// flagging the all-off pattern as blank and anything outside the table as bad.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        blank  = (seg == BLANK_CODE);
        bad    = (seg != BLANK_CODE);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                nibble = 4'(i);
                bad    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Display-bus monitor: synchronizes a multiplexed active-low 7-segment bus,
// qualifies each digit over STABLE_CYCLES samples and latches its decoded value.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   bad,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_idx,
    output logic                    frame_done,
    output logic                    conflict
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [7:0]            seg_meta_reg, seg_sync_reg, prev_seg_reg;
    logic [NUM_DIGITS-1:0] an_meta_reg, an_sync_reg, prev_an_reg;
    logic                  vld_meta_reg, vld_sync_reg;

    qual_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0] mask_reg;
    logic                  conflict_reg, upd_valid_reg, frame_done_reg;
    logic [IDX_W-1:0]      upd_idx_reg;

    logic [NUM_DIGITS-1:0] an_act, mask_set;
    logic                  one_hot, multi, same, capture;
    logic [IDX_W-1:0]      act_idx;
    logic [3:0]            dec_nibble;
    logic                  dec_blank, dec_bad;

    // vld_* marks when the synchronizer holds real pin samples rather than
    // reset zeros, which would otherwise look like every anode asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_reg <= '0;
            seg_sync_reg <= '0;
            an_meta_reg  <= '0;
            an_sync_reg  <= '0;
            vld_meta_reg <= 1'b0;
            vld_sync_reg <= 1'b0;
        end else begin
            seg_meta_reg <= seg_n;
            seg_sync_reg <= seg_meta_reg;
            an_meta_reg  <= an_n;
            an_sync_reg  <= an_meta_reg;
            vld_meta_reg <= 1'b1;
            vld_sync_reg <= vld_meta_reg;
        end
    end

    assign an_act  = ~an_sync_reg;
    assign one_hot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
    assign multi   = (an_act != '0) && !one_hot;
    assign same    = (seg_sync_reg == prev_seg_reg) && (an_sync_reg == prev_an_reg);

    always_comb begin
        act_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_act[i]) begin
                act_idx = IDX_W'(i);
            end
        end
    end

    seg7_pattern_decode u_decode (
        .seg    (seg_sync_reg[6:0]),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .bad    (dec_bad)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (vld_sync_reg) begin
            case (state_reg)
                IDLE: begin
                    if (one_hot) begin
                        state_next = DWELL;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        cnt_next   = '0;
                    end
                end
                DWELL: begin
                    if (!one_hot) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (!same) begin
                        cnt_next   = CNT_W'(1);
                    end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
                        // This sample is the STABLE_CYCLES-th identical one.
                        capture    = 1'b1;
                        state_next = HELD;
                        cnt_next   = CNT_W'(STABLE_CYCLES);
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!one_hot) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (!same) begin
                        state_next = DWELL;
                        cnt_next   = CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // The one-hot anode vector doubles as the mask bit of the active digit.
    assign mask_set = mask_reg | an_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            prev_seg_reg   <= '0;
            prev_an_reg    <= '0;
            mask_reg       <= '0;
            conflict_reg   <= 1'b0;
            upd_valid_reg  <= 1'b0;
            upd_idx_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            prev_seg_reg   <= seg_sync_reg;
            prev_an_reg    <= an_sync_reg;
            conflict_reg   <= vld_sync_reg && multi;
            upd_valid_reg  <= capture;
            frame_done_reg <= capture && (&mask_set);
            if (capture) begin
                upd_idx_reg <= act_idx;
                mask_reg    <= (&mask_set) ? '0 : mask_set;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] hex_reg;
            logic       dp_reg, blank_reg, bad_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hex_reg   <= 4'h0;
                    dp_reg    <= 1'b0;
                    blank_reg <= 1'b1;
                    bad_reg   <= 1'b0;
                end else if (capture && an_act[gi]) begin
                    hex_reg   <= (dec_blank || dec_bad) ? 4'h0 : dec_nibble;
                    dp_reg    <= ~seg_sync_reg[7];
                    blank_reg <= dec_blank;
                    bad_reg   <= dec_bad;
                end
            end

            assign hex_out[4*gi +: 4] = hex_reg;
            assign dp_out[gi]         = dp_reg;
            assign blank[gi]          = blank_reg;
            assign bad[gi]            = bad_reg;
        end
    endgenerate

    assign upd_valid  = upd_valid_reg;
    assign upd_idx    = upd_idx_reg;
    assign frame_done = frame_done_reg;
    assign conflict   = conflict_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboarded bench for seg7_scan_decoder: each driven digit pattern pushes its
// expected capture; a negedge monitor pops and compares on every upd_valid.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg_n;
    logic [ND-1:0] an_n;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] dp_out, blank, bad;
    logic          upd_valid, frame_done, conflict;
    logic [IW-1:0] upd_idx;

    typedef struct {
        int         idx;
        logic [3:0] nib;
        logic       dp;
        logic       blk;
        logic       bd;
        logic       frm;
    } exp_t;

    exp_t    sb_q[$];
    exp_t    mon_e;
    int      n_checks = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      upd_cnt = 0;
    int      frame_cnt = 0;
    int      conflict_cnt = 0;
    int      last_upd_cyc = 0;
    int      stim_cyc, u0, f0, c0;
    logic [ND-1:0] model_mask;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .IDX_W         (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .blank      (blank),
        .bad        (bad),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .frame_done (frame_done),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_capture(input int idx, input logic [3:0] nib,
                                  input logic dp, input logic blk, input logic bd);
        exp_t e;
        e.idx = idx;
        e.nib = nib;
        e.dp  = dp;
        e.blk = blk;
        e.bd  = bd;
        model_mask[idx] = 1'b1;
        e.frm = (model_mask == '1);
        if (e.frm) model_mask = '0;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge n cycles later.
    task automatic drive(input logic [ND-1:0] an, input logic [7:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        $display("drive an_n=%b seg_n=%02h for %0d cycles", an, seg, n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_hex"},        hex_out,    '0);
        check({pfx, "_dp"},         dp_out,     '0);
        check({pfx, "_blank"},      blank,      4'hF);
        check({pfx, "_bad"},        bad,        '0);
        check({pfx, "_upd_valid"},  upd_valid,  0);
        check({pfx, "_upd_idx"},    upd_idx,    0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_conflict"},   conflict,   0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (conflict) conflict_cnt++;
            if (frame_done) frame_cnt++;
            if (upd_valid) begin
                upd_cnt++;
                last_upd_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_upd", upd_valid, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("capture idx=%0d hex=%0h dp=%b blank=%b bad=%b frame=%b",
                             upd_idx, hex_out[4*mon_e.idx +: 4], dp_out[mon_e.idx],
                             blank[mon_e.idx], bad[mon_e.idx], frame_done);
                    check("upd_idx",    upd_idx, mon_e.idx);
                    check("hex_digit",  hex_out[4*mon_e.idx +: 4], mon_e.nib);
                    check("dp_digit",   dp_out[mon_e.idx], mon_e.dp);
                    check("blank_digit", blank[mon_e.idx], mon_e.blk);
                    check("bad_digit",  bad[mon_e.idx], mon_e.bd);
                    check("frame_done", frame_done, mon_e.frm);
                end
            end else begin
                check("stray_frame", frame_done, 0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        an_n       = '1;
        seg_n      = 8'hFF;
        model_mask = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single digit 0, latency measured from the stimulus edge.
        u0 = upd_cnt;
        expect_capture(0, 4'h0, 1'b0, 1'b0, 1'b0);
        stim_cyc = cyc;
        drive(4'b1110, 8'hC0, 10);
        check("t1_upd_count", upd_cnt - u0, 1);
        check("t1_latency", last_upd_cyc - stim_cyc, SC + 2);
        check("t1_hex0", hex_out[3:0], 4'h0);
        check("t1_blank0", blank[0], 0);

        // Full scan of four digits completes a frame on digit 3.
        f0 = frame_cnt;
        expect_capture(0, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(4'b1110, 8'hF9, 8);
        expect_capture(1, 4'h2, 1'b0, 1'b0, 1'b0);
        drive(4'b1101, 8'hA4, 8);
        expect_capture(2, 4'h3, 1'b0, 1'b0, 1'b0);
        drive(4'b1011, 8'hB0, 8);
        expect_capture(3, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'b0111, 8'h0E, 8);
        check("t2_hex_out", hex_out, 16'hF321);
        check("t2_dp_out", dp_out, 4'b1000);
        check("t2_blank", blank, 4'b0000);
        check("t2_frame_count", frame_cnt - f0, 1);

        // Dwell one sample short of qualification.
        u0 = upd_cnt;
        drive(4'b1101, 8'hA4, SC - 1);
        drive(4'b1111, 8'hFF, 6);
        check("t3_no_upd", upd_cnt - u0, 0);
        check("t3_hex_out", hex_out, 16'hF321);
        check("t3_dp_out", dp_out, 4'b1000);

        // Two anodes asserted at once.
        u0 = upd_cnt;
        c0 = conflict_cnt;
        drive(4'b1100, 8'hFF, 3);
        drive(4'b1111, 8'hFF, 6);
        check("t4_conflict_count", conflict_cnt - c0, 3);
        check("t4_no_upd", upd_cnt - u0, 0);

        // Blank then invalid pattern on digit 2.
        expect_capture(2, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(4'b1011, 8'hFF, 8);
        check("t5_blank2", blank[2], 1);
        check("t5_hex2_blank", hex_out[11:8], 4'h0);
        expect_capture(2, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(4'b1011, 8'hD5, 8);
        check("t5_bad2", bad[2], 1);
        check("t5_blank2_cleared", blank[2], 0);
        check("t5_hex2_bad", hex_out[11:8], 4'h0);

        // Reset mid-frame clears the mask, so digits 2 and 3 alone are no frame.
        expect_capture(0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(4'b1110, 8'hC0, 8);
        expect_capture(1, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(4'b1101, 8'hF9, 8);
        an_n  = '1;
        seg_n = 8'hFF;
        rst   = 1'b1;
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst        = 1'b0;
        model_mask = '0;
        f0         = frame_cnt;
        repeat (2) @(negedge clk);
        expect_capture(2, 4'h3, 1'b0, 1'b0, 1'b0);
        drive(4'b1011, 8'hB0, 8);
        expect_capture(3, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'b0111, 8'h0E, 8);
        drive(4'b1111, 8'hFF, 4);
        check("t6_no_frame", frame_cnt - f0, 0);
        check("t6_hex_out", hex_out, 16'hF300);
        check("t6_blank", blank, 4'b0011);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
